// File: rtl/bundle_queue.sv
// Elastic FIFO of 4-slot VLIW bundles between fetch and decode.
// Define BUNDLE_QUEUE_BYPASS_EN for a same-cycle path from fetch to decode while empty.
module bundle_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned IW          = 22,
    parameter int unsigned PCW         = 10,
    parameter int unsigned HOLD_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IW-1:0]              in_a0,
    input  logic [IW-1:0]              in_a1,
    input  logic [IW-1:0]              in_ls,
    input  logic [IW-1:0]              in_m,
    input  logic [PCW-1:0]             in_pc,
    input  logic                       flush,
    input  logic                       dec_ready,
    output logic                       out_valid,
    output logic [IW-1:0]              out_a0,
    output logic [IW-1:0]              out_a1,
    output logic [IW-1:0]              out_ls,
    output logic [IW-1:0]              out_m,
    output logic [PCW-1:0]             out_pc,
    output logic                       fetch_hold,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = 4 * IW + PCW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_CNT = CW'(DEPTH - HOLD_MARGIN);

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_bypass;
    logic          w_pop;
    logic          w_push;
    logic          w_wr;
    logic          w_rd;
    logic          w_drop;
    logic [BW-1:0] w_in;
    logic [BW-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_in    = {in_a0, in_a1, in_ls, in_m, in_pc};
    assign w_head  = r_mem[r_rd];

`ifdef BUNDLE_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && in_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid = !w_empty || w_bypass;
    assign w_pop     = out_valid && dec_ready && !flush;
    assign w_push    = in_valid && !flush && (!w_full || w_pop);
    // A bypassed bundle that decode takes immediately never touches storage.
    assign w_wr      = w_push && !(w_bypass && dec_ready);
    assign w_rd      = w_pop && !w_bypass;
    assign w_drop    = in_valid && !flush && w_full && !w_pop;

    always_comb begin
        {out_a0, out_a1, out_ls, out_m, out_pc} = '0;
        if (!w_empty) begin
            {out_a0, out_a1, out_ls, out_m, out_pc} = w_head;
        end else if (w_bypass) begin
            {out_a0, out_a1, out_ls, out_m, out_pc} = w_in;
        end
    end

    assign fetch_hold = (r_count >= HOLD_CNT) && !flush;
    assign count      = r_count;
    assign overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr) begin
            r_mem[r_wr] <= w_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_rd) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bundle_queue.sv
// Directed self-checking bench for bundle_queue (DEPTH=4, HOLD_MARGIN=2).
module tb_bundle_queue;
    localparam int unsigned IW  = 22;
    localparam int unsigned PCW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [IW-1:0] in_a0, in_a1, in_ls, in_m;
    logic [PCW-1:0] in_pc;
    logic          flush;
    logic          dec_ready;
    logic          out_valid;
    logic [IW-1:0] out_a0, out_a1, out_ls, out_m;
    logic [PCW-1:0] out_pc;
    logic          fetch_hold;
    logic [2:0]    count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    bundle_queue #(.DEPTH(4), .IW(IW), .PCW(PCW), .HOLD_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_a0(in_a0), .in_a1(in_a1), .in_ls(in_ls), .in_m(in_m), .in_pc(in_pc),
        .flush(flush), .dec_ready(dec_ready), .out_valid(out_valid),
        .out_a0(out_a0), .out_a1(out_a1), .out_ls(out_ls), .out_m(out_m), .out_pc(out_pc),
        .fetch_hold(fetch_hold), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_pcs [4] = '{2, 3, 4, 9};
    int sent, rcv, cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0;
        in_a0 = '0; in_a1 = '0; in_ls = '0; in_m = '0; in_pc = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, out_valid}, 0);
        check_eq("rst_count", {29'd0, count}, 0);
        check_eq("rst_hold", {31'd0, fetch_hold}, 0);
        check_eq("rst_ovf", {31'd0, overflow}, 0);
        check_eq("rst_pc", {22'd0, out_pc}, 0);

        // Single pass
        in_valid = 1'b1; in_pc = 10'h005; in_a0 = 22'h12345; dec_ready = 1'b1;
        #1;
`ifdef BUNDLE_QUEUE_BYPASS_EN
        check_eq("byp_valid", {31'd0, out_valid}, 1);
        check_eq("byp_pc", {22'd0, out_pc}, 32'h005);
`else
        check_eq("sp_pre_valid", {31'd0, out_valid}, 0);
`endif
        step();
        in_valid = 1'b0;
        #1;
`ifndef BUNDLE_QUEUE_BYPASS_EN
        check_eq("sp_valid", {31'd0, out_valid}, 1);
        check_eq("sp_pc", {22'd0, out_pc}, 32'h005);
        check_eq("sp_a0", {10'd0, out_a0}, 32'h12345);
        check_eq("sp_count1", {29'd0, count}, 1);
        step();
`endif
        check_eq("sp_count0", {29'd0, count}, 0);
        check_eq("sp_empty", {31'd0, out_valid}, 0);

        // Fill and stall
        dec_ready = 1'b0;
        for (int pc = 1; pc <= 4; pc++) begin
            in_valid = 1'b1; in_pc = PCW'(pc); in_a0 = IW'(pc * 16);
            step();
            check_eq("fill_count", {29'd0, count}, pc);
            check_eq("fill_hold", {31'd0, fetch_hold}, (pc >= 2) ? 1 : 0);
        end
        check_eq("fill_head", {22'd0, out_pc}, 1);
        in_pc = 10'd5;
        step();
        check_eq("drop_count", {29'd0, count}, 4);
        check_eq("drop_ovf", {31'd0, overflow}, 1);
        check_eq("drop_head", {22'd0, out_pc}, 1);
        check_eq("drop_a0", {10'd0, out_a0}, 32'h10);

        // Full with simultaneous push and pop
        in_pc = 10'd9; dec_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("pp_count", {29'd0, count}, 4);
        check_eq("pp_ovf", {31'd0, overflow}, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("pp_order", {22'd0, out_pc}, 32'(exp_pcs[i]));
            step();
        end
        check_eq("pp_drained", {29'd0, count}, 0);

        // Flush mid-stream
        dec_ready = 1'b0;
        for (int pc = 16; pc < 19; pc++) begin
            in_valid = 1'b1; in_pc = PCW'(pc);
            step();
        end
        check_eq("fl_pre_count", {29'd0, count}, 3);
        flush = 1'b1; in_pc = 10'h020; dec_ready = 1'b1;
        #1;
        check_eq("fl_hold_mask", {31'd0, fetch_hold}, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("fl_count", {29'd0, count}, 0);
        check_eq("fl_valid", {31'd0, out_valid}, 0);
        check_eq("fl_ovf", {31'd0, overflow}, 1);
        in_valid = 1'b1; in_pc = 10'h040; dec_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check_eq("fl_new_head", {22'd0, out_pc}, 32'h040);
        check_eq("fl_new_count", {29'd0, count}, 1);
        dec_ready = 1'b1;
        step();
        check_eq("fl_new_pop", {29'd0, count}, 0);

        // Reset clears the sticky overflow
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_ovf_clr", {31'd0, overflow}, 0);

        // Wrap-around stream, fetch honours fetch_hold
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 10 && cyc < 200) begin
            dec_ready = ((cyc % 2) == 0);
            in_valid  = (sent < 10) && !fetch_hold;
            in_pc     = PCW'(sent);
            in_a0     = IW'(sent + 100);
            #1;
`ifdef BUNDLE_QUEUE_BYPASS_EN
            if (cyc == 0) begin
                check_eq("wr_byp_valid", {31'd0, out_valid}, 1);
                check_eq("wr_byp_pc", {22'd0, out_pc}, 0);
            end
`endif
            if (out_valid && dec_ready) begin
                check_eq("wr_pc", {22'd0, out_pc}, 32'(rcv));
                check_eq("wr_a0", {10'd0, out_a0}, 32'(rcv + 100));
                rcv++;
            end
            if (in_valid) sent++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("wr_rcv", 32'(rcv), 10);
        check_eq("wr_ovf", {31'd0, overflow}, 0);
        check_eq("wr_count", {29'd0, count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
